// File: rtl/sfifo_param.sv
// rtl/sfifo_param.sv - parameterised synchronous FIFO with status and sticky error flags
module sfifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int PTR_BITS = 4,
  parameter int CNT_BITS = 5,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                read_n,
  input  logic                write_n,
  output logic [WIDTH-1:0]    data_out,
  output logic                data_valid,
  output logic [CNT_BITS-1:0] count,
  output logic                full,
  output logic                empty,
  output logic                half,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [CNT_BITS-1:0] FULL_LVL = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] HALF_LVL = CNT_BITS'((DEPTH + 1) / 2);
  localparam logic [CNT_BITS-1:0] AF_LVL   = CNT_BITS'(AF_LEVEL);
  localparam logic [CNT_BITS-1:0] AE_LVL   = CNT_BITS'(AE_LEVEL);
  localparam logic [PTR_BITS-1:0] LAST_PTR = PTR_BITS'(DEPTH - 1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [CNT_BITS-1:0] cnt;
  logic                rd_ok;
  logic                wr_ok;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths use every slot.
  function automatic logic [PTR_BITS-1:0] ptr_next(input logic [PTR_BITS-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
  assign rd_ok = !read_n && (cnt != '0);
  assign wr_ok = !write_n && ((cnt < FULL_LVL) || rd_ok);

  assign count        = cnt;
  assign full         = (cnt == FULL_LVL);
  assign empty        = (cnt == '0);
  assign half         = (cnt >= HALF_LVL);
  assign almost_full  = (cnt >= AF_LVL);
  assign almost_empty = (cnt <= AE_LVL);

  always_ff @(posedge clock) begin
    if (reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      data_valid <= rd_ok;
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= ptr_next(rd_ptr);
      end
      if (wr_ok) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (wr_ok && !rd_ok) begin
        cnt <= cnt + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        cnt <= cnt - 1'b1;
      end
      if (!write_n && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (!read_n && (cnt == '0)) begin
        underflow <= 1'b1;
      end
    end
  end

  // Storage is never cleared; reset only blocks the write on its own edge.
  always_ff @(posedge clock) begin
    if (wr_ok && !reset_n) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: doc/sfifo_param.md
SFIFO_PARAM -- requirements
Module: sfifo_param

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits.
REQ-002 Parameter DEPTH, default 16: FIFO capacity in words; any integer 2..256, power of two not required.
REQ-003 Parameter PTR_BITS, default 4: pointer width; must satisfy 2^PTR_BITS >= DEPTH.
REQ-004 Parameter CNT_BITS, default 5: count width; must satisfy 2^CNT_BITS > DEPTH.
REQ-005 Parameter AF_LEVEL, default 14: almost_full threshold in words.
REQ-006 Parameter AE_LEVEL, default 2: almost_empty threshold in words.
REQ-007 clock  input  1  sole clock; all state updates on its rising edge.
REQ-008 reset_n  input  1  reset, synchronous and active-high: asserted when 1, sampled on the clock rising edge.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 read_n  input  1  read request, active low.
REQ-011 write_n  input  1  write request, active low.
REQ-012 data_out  output  WIDTH  registered read data.
REQ-013 data_valid  output  1  one-cycle pulse; data_out holds a newly read word.
REQ-014 count  output  CNT_BITS  number of words stored.
REQ-015 full, empty, half, almost_full, almost_empty  output  1 each  status flags.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Storage: DEPTH x WIDTH array; read and write pointers wrap from DEPTH-1 to 0.
REQ-018 Write acceptance: accepted when write_n=0 and (count<DEPTH, or read accepted in the same cycle).
REQ-019 Read acceptance: accepted when read_n=0 and count>0; a read with count=0 is not accepted, even if a write is accepted in the same cycle.
REQ-020 Accepted write: stores data_in at the write pointer; write pointer advances by 1 with wrap.
REQ-021 Accepted read: data_out is loaded with the word at the read pointer on the same edge (1-cycle latency); data_valid=1 in the following cycle; read pointer advances by 1 with wrap.
REQ-022 data_out holds its value when no read is accepted; data_valid=0 in that case.
REQ-023 Count: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds DEPTH and never goes below 0.
REQ-024 Full + simultaneous read and write: both accepted; count stays DEPTH; the read returns the oldest word.
REQ-025 Empty + simultaneous read and write: write accepted, read ignored; count becomes 1; data_valid stays 0.
REQ-026 Flags, combinational from count:
  - full = (count==DEPTH)
  - empty = (count==0)
  - half = (count >= (DEPTH+1)/2)
  - almost_full = (count >= AF_LEVEL)
  - almost_empty = (count <= AE_LEVEL)
REQ-027 overflow: set when write_n=0 and the write is rejected; remains 1 until reset.
REQ-028 underflow: set when read_n=0 and count=0; remains 1 until reset.
REQ-029 Rejected operations: change no pointer, count, memory word or data_out.
REQ-030 Ordering: words are read in exactly the order written, including across pointer wrap.

Reset
REQ-031 When reset_n=1 at a rising edge, the following take effect on that edge, overriding any read or write in the same cycle:
  - read pointer, write pointer, count = 0
  - data_out = 0; data_valid = 0; overflow = underflow = 0
REQ-032 Memory contents are not reset; after reset they are unreachable until rewritten.
REQ-033 Reset asserted mid-stream discards all stored words; the FIFO is empty on the next cycle.

Verification
REQ-034 Write 0x01..0x10 (16 words), then read 16 -> data_out 0x01..0x10 in order, each 1 cycle after its read; full=1 after the 16th write; empty=1 after the 16th read.
REQ-035 Fill to 16, then a 17th write of 0xAA -> overflow=1, count=16, 0xAA never read back; 16 reads return the original 16 words.
REQ-036 From empty, read_n=0 and write_n=0 with data_in=0x5C -> underflow=1, count=1, data_valid=0; next read returns 0x5C.
REQ-037 Full, 20 cycles of simultaneous read and write -> count stays 16, no overflow, outputs in write order across pointer wrap.
REQ-038 Threshold sweep: count 2 -> almost_empty=1; count 3 -> almost_empty=0; count 8 -> half=1; count 14 -> almost_full=1.
REQ-039 With count=9 and overflow=1, assert reset_n=1 together with a write -> next cycle count=0, empty=1, overflow=0, data_out=0.
